// File: rtl/countdown_timer.sv
// Loadable MM:SS BCD countdown timer with start/stop control, tick prescaler
// and expiry state. Digit encoding matches the up-counting BCD timer.
module countdown_timer #(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] ld_min_tens,
  input  logic [3:0] ld_min_units,
  input  logic [2:0] ld_sec_tens,
  input  logic [3:0] ld_sec_units,
  output logic [2:0] min_tens,
  output logic [3:0] min_units,
  output logic [2:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       expired
);

  localparam int PW = $clog2(TICKS_PER_SEC) + 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  function automatic logic [2:0] clamp_tens(input logic [2:0] v);
    return (v > 3'd5) ? 3'd5 : v;
  endfunction

  function automatic logic [3:0] clamp_units(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // One-second decrement with BCD borrow; never called on 00:00.
  function automatic logic [13:0] dec_mmss(input logic [13:0] v);
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
    {mt, mu, st, su} = v;
    if (su == 4'd0) begin
      su = 4'd9;
      if (st == 3'd0) begin
        st = 3'd5;
        if (mu == 4'd0) begin
          mu = 4'd9;
          mt = mt - 3'd1;
        end else begin
          mu = mu - 4'd1;
        end
      end else begin
        st = st - 3'd1;
      end
    end else begin
      su = su - 4'd1;
    end
    return {mt, mu, st, su};
  endfunction

  state_t        r_state;
  logic [PW-1:0] r_pre;
  logic [2:0]    r_min_tens;
  logic [3:0]    r_min_units;
  logic [2:0]    r_sec_tens;
  logic [3:0]    r_sec_units;
  logic          r_running;
  logic          r_expired;

  logic [13:0] w_cur;
  logic [13:0] w_dec;
  logic        w_cur_zero;
  logic        w_dec_zero;

  assign w_cur      = {r_min_tens, r_min_units, r_sec_tens, r_sec_units};
  assign w_dec      = dec_mmss(w_cur);
  assign w_cur_zero = (w_cur == 14'd0);
  assign w_dec_zero = (w_dec == 14'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_min_tens  <= '0;
      r_min_units <= '0;
      r_sec_tens  <= '0;
      r_sec_units <= '0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
    end else if (load) begin
      r_state     <= IDLE;
      r_pre       <= '0;
      r_min_tens  <= clamp_tens(ld_min_tens);
      r_min_units <= clamp_units(ld_min_units);
      r_sec_tens  <= clamp_tens(ld_sec_tens);
      r_sec_units <= clamp_units(ld_sec_units);
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
    end else if (stop && r_state == RUN) begin
      r_state   <= PAUSED;
      r_running <= 1'b0;
    end else if (start && r_state == IDLE && !w_cur_zero) begin
      r_state   <= RUN;
      r_pre     <= '0;
      r_running <= 1'b1;
    end else if (start && r_state == PAUSED) begin
      // Resume keeps the partial second accumulated before the pause.
      r_state   <= RUN;
      r_running <= 1'b1;
    end else if (tick && r_state == RUN) begin
      if (r_pre == PRE_MAX) begin
        r_pre <= '0;
        {r_min_tens, r_min_units, r_sec_tens, r_sec_units} <= w_dec;
        if (w_dec_zero) begin
          r_state   <= EXPIRED;
          r_running <= 1'b0;
          r_expired <= 1'b1;
        end
      end else begin
        r_pre <= r_pre + 1'b1;
      end
    end
  end

  assign min_tens  = r_min_tens;
  assign min_units = r_min_units;
  assign sec_tens  = r_sec_tens;
  assign sec_units = r_sec_units;
  assign running   = r_running;
  assign expired   = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one instance at 1 tick/s, one at 4 ticks/s,
// both driven by the same stimulus.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] ld_min_tens = '0;
  logic [3:0] ld_min_units = '0;
  logic [2:0] ld_sec_tens = '0;
  logic [3:0] ld_sec_units = '0;

  logic [2:0] min_tens, min_tens4;
  logic [3:0] min_units, min_units4;
  logic [2:0] sec_tens, sec_tens4;
  logic [3:0] sec_units, sec_units4;
  logic       running, running4;
  logic       expired, expired4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICKS_PER_SEC(1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .stop(stop),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .running(running), .expired(expired)
  );

  countdown_timer #(.TICKS_PER_SEC(4)) dut4 (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start), .stop(stop),
    .ld_min_tens(ld_min_tens), .ld_min_units(ld_min_units),
    .ld_sec_tens(ld_sec_tens), .ld_sec_units(ld_sec_units),
    .min_tens(min_tens4), .min_units(min_units4), .sec_tens(sec_tens4), .sec_units(sec_units4),
    .running(running4), .expired(expired4)
  );

  function automatic logic [13:0] bcd(input int mt, input int mu, input int st, input int su);
    return {3'(mt), 4'(mu), 3'(st), 4'(su)};
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic do_load(input int mt, input int mu, input int st, input int su);
    ld_min_tens = 3'(mt); ld_min_units = 4'(mu); ld_sec_tens = 3'(st); ld_sec_units = 4'(su);
    load = 1'b1;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
    end
  endtask

  function automatic logic [13:0] val1();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  function automatic logic [13:0] val4();
    return {min_tens4, min_units4, sec_tens4, sec_units4};
  endfunction

  initial begin
    #2;
    reset = 1'b1; step(); reset = 1'b0;
    chk("reset_digits", val1(), bcd(0,0,0,0));
    chk("reset_running", 14'(running), 14'd0);
    chk("reset_expired", 14'(expired), 14'd0);

    do_load(0,1,0,0);
    chk("load_0100", val1(), bcd(0,1,0,0));
    start = 1'b1; step();
    chk("start_running", 14'(running), 14'd1);
    ticks(1);
    chk("first_tick", val1(), bcd(0,0,5,9));
    chk("first_tick_running", 14'(running), 14'd1);
    ticks(58);
    chk("at_0001", val1(), bcd(0,0,0,1));
    chk("at_0001_expired", 14'(expired), 14'd0);
    ticks(1);
    chk("expiry_digits", val1(), bcd(0,0,0,0));
    chk("expiry_expired", 14'(expired), 14'd1);
    chk("expiry_running", 14'(running), 14'd0);
    start = 1'b1; tick = 1'b1; step();
    chk("expired_start_tick", val1(), bcd(0,0,0,0));
    chk("expired_stays", 14'(expired), 14'd1);
    do_load(0,2,3,0);
    chk("load_after_expiry", val1(), bcd(0,2,3,0));
    chk("load_clears_expired", 14'(expired), 14'd0);
    chk("load_idle_running", 14'(running), 14'd0);

    do_load(1,0,0,0);
    start = 1'b1; step();
    ticks(1);
    chk("borrow_1000", val1(), bcd(0,9,5,9));
    do_load(0,0,1,0);
    start = 1'b1; step();
    ticks(1);
    chk("borrow_0010", val1(), bcd(0,0,0,9));

    do_load(7,12,6,15);
    chk("clamp", val1(), bcd(5,9,5,9));
    do_load(0,0,0,0);
    start = 1'b1; step();
    chk("zero_start_running", 14'(running), 14'd0);
    ticks(3);
    chk("zero_start_digits", val1(), bcd(0,0,0,0));
    chk("zero_start_expired", 14'(expired), 14'd0);

    do_load(0,0,0,3);
    start = 1'b1; step();
    chk("prio_run", 14'(running), 14'd1);
    ld_min_tens = 3'd0; ld_min_units = 4'd0; ld_sec_tens = 3'd0; ld_sec_units = 4'd7;
    tick = 1'b1; load = 1'b1; step();
    chk("tick_load_digits", val1(), bcd(0,0,0,7));
    chk("tick_load_idle", 14'(running), 14'd0);
    start = 1'b1; step();
    tick = 1'b1; stop = 1'b1; step();
    chk("tick_stop_digits", val1(), bcd(0,0,0,7));
    chk("tick_stop_paused", 14'(running), 14'd0);
    start = 1'b1; tick = 1'b1; step();
    chk("resume_tick_start", val1(), bcd(0,0,0,7));
    chk("resume_running", 14'(running), 14'd1);
    ticks(1);
    chk("resume_count", val1(), bcd(0,0,0,6));
    start = 1'b1; stop = 1'b1; step();
    chk("start_stop_running", 14'(running), 14'd0);
    ticks(2);
    chk("start_stop_digits", val1(), bcd(0,0,0,6));

    do_load(0,0,0,5);
    start = 1'b1; step();
    ticks(3);
    chk("p4_three_ticks", val4(), bcd(0,0,0,5));
    stop = 1'b1; step();
    ticks(10);
    chk("p4_paused_digits", val4(), bcd(0,0,0,5));
    chk("p4_paused_running", 14'(running4), 14'd0);
    start = 1'b1; step();
    chk("p4_resumed", 14'(running4), 14'd1);
    ticks(1);
    chk("p4_prescaler_kept", val4(), bcd(0,0,0,4));
    ticks(3);
    chk("p4_partial", val4(), bcd(0,0,0,4));
    ticks(1);
    chk("p4_full_second", val4(), bcd(0,0,0,3));

    do_load(0,2,3,0);
    start = 1'b1; step();
    ticks(5);
    chk("pre_reset_digits", val1(), bcd(0,2,2,5));
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_reset_digits", val1(), bcd(0,0,0,0));
    chk("mid_reset_running", 14'(running), 14'd0);
    chk("mid_reset_expired", 14'(expired), 14'd0);
    start = 1'b1; step();
    chk("reset_start_ignored", 14'(running), 14'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
